store_write_buffer: RTL
=======================

Name: store_write_buffer

Overview:
- Buffers store requests between the single-cycle datapath's store path and the data memory write port.
- Accepts byte, half and word stores (the sb/sh/sw classes) and converts each to a word-aligned address, lane-shifted data and a 4-bit byte enable.
- Queues them in a small FIFO and drains them to memory under a valid/ready handshake.
- Flags loads that hit a pending store so the pipeline can stall.

Parameters:
- DEPTH, 4, number of buffered store entries; power of two, 2..16.
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- st_valid  input  1  store request present
- st_ready  output  1  store request accepted this cycle when st_valid=1
- st_addr  input  ADDR_W  byte address of store
- st_data  input  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0])
- st_size  input  2  00=byte (sb), 01=half (sh), 10=word (sw), 11=illegal
- misalign_err  output  1  one-cycle pulse: rejected store (misaligned or illegal size)
- mem_wr_valid  output  1  head entry presented to memory
- mem_wr_ready  input  1  memory accepts head entry
- mem_addr  output  ADDR_W  word-aligned address ([1:0]=00)
- mem_wdata  output  DATA_W  lane-shifted write data
- mem_be  output  4  byte enables, bit i = byte lane i
- ld_valid  input  1  load being issued
- ld_addr  input  ADDR_W  load byte address
- ld_stall  output  1  load word matches a pending entry
- empty  output  1  buffer holds no entries

Behaviour:
- Reset (async assert, sync release): count=0, head=tail=0, all entry valid bits cleared. Outputs: mem_wr_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, misalign_err=0, ld_stall=0, empty=1, st_ready=1. Asserting reset mid-operation discards all pending stores.
- Lane conversion:
  - lane = st_addr[1:0].
  - byte: be=0001<<lane, data=st_data[7:0] replicated to every lane.
  - half: legal only if lane[0]=0; be=0011<<lane, data={2{st_data[15:0]}}.
  - word: legal only if lane=00; be=1111, data=st_data.
  - Entry address = {st_addr[ADDR_W-1:2],2'b00}.
- Error handling: a misaligned request, or st_size=11, is not enqueued. It is consumed (st_ready=1 regardless of fullness) and misalign_err pulses high in the following cycle.
- Enqueue: st_ready = (count<DEPTH) for legal requests. Push occurs on st_valid&st_ready. Entry visible on the mem port at the earliest one cycle later (registered FIFO, no bypass).
- Drain:
  - mem_wr_valid = !empty; mem_addr, mem_wdata and mem_be come from the head entry.
  - Pop on mem_wr_valid&mem_wr_ready. Head entry outputs hold stable while valid&!ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full + pop in the same cycle: push still refused that cycle (st_ready depends only on registered count).
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH; empty = (count==0).
- Load hazard: ld_stall = ld_valid & (any valid entry with word address == ld_addr[ADDR_W-1:2]). Purely combinational, no byte-enable refinement. An entry popping this cycle still counts as matching.
- Ordering: memory sees stores in strict acceptance order.

Optional Feature:
- Macro: STORE_BUFFER_MERGE_EN.
- Enabled: a legal store whose word address equals the youngest valid entry merges into that entry instead of allocating a new one.
  - Merged be = old_be | new_be; lanes with new_be set take the new data.
  - Merge is accepted even when full.
  - Merge is blocked (normal push path) when the youngest entry is also the head and is popping this cycle.
- Disabled: every legal store allocates a new entry.

Decomposition:
- Shared package store_buffer_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL.
  - entry struct {addr, data, be, valid}.
  - function size_to_be(size, lane).
- One sub-module store_lane_align (combinational): st_size, st_addr[1:0], st_data → be, lane data, err. The FIFO, pointers, hazard compare and merge logic stay in the top module.

Test Plan:
- sb addr=0x00000013 data=0xAB, mem_wr_ready=1 → next cycle mem_addr=0x10, mem_be=1000, mem_wdata[31:24]=0xAB, then empty=1.
- sh addr=0x21 → st_ready=1, misalign_err=1 next cycle, no mem_wr_valid. Also st_size=11 → same response.
- mem_wr_ready=0; 4 sw to 0x0,0x4,0x8,0xC → st_ready=0 on the fifth. Release ready → four writes in order, 0x0 first, all be=1111.
- Pending sw at 0x40; ld_valid with ld_addr=0x42 → ld_stall=1. ld_addr=0x44 → ld_stall=0.
- Assert rst_n=0 with 3 entries pending → mem_wr_valid=0 and empty=1 immediately (async); nothing written after release.
- STORE_BUFFER_MERGE_EN, ready=0: sb 0x50=0x11 then sb 0x51=0x22 → single entry be=0011, mem_wdata[15:0]=0x2211. Without the macro → two entries.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types for the store write buffer: size encodings, the buffered entry and byte-enable helper.
// Entry field widths track the buffer's default 32-bit address and data widths.
package store_buffer_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_LANES  = SB_DATA_W / 8;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } st_size_e;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [SB_LANES-1:0]  be;
        logic                 valid;
    } sb_entry_t;

    function automatic logic [3:0] size_to_be(input st_size_e size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = 4'b0011 << lane;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Converts a right-aligned sb/sh/sw request into lane-shifted data and byte enables,
// flagging misaligned halves/words and the illegal size encoding.
module store_lane_align
    import store_buffer_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_data,
    output logic        o_err
);

    st_size_e w_size;

    assign w_size = st_size_e'(i_size);

    // Data is replicated across lanes so the byte enables alone select what is written.
    always_comb begin
        o_be   = size_to_be(w_size, i_lane);
        o_data = i_data;
        o_err  = 1'b0;
        case (w_size)
            SZ_BYTE: o_data = {4{i_data[7:0]}};
            SZ_HALF: begin
                o_data = {2{i_data[15:0]}};
                o_err  = i_lane[0];
            end
            SZ_WORD: o_err = (i_lane != 2'b00);
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: aligns stores, queues them in a DEPTH-entry FIFO and drains to memory.
// Define STORE_BUFFER_MERGE_EN to coalesce same-word stores into the youngest entry.
module store_write_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [1:0]        st_size,
    output logic              misalign_err,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_stall,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    sb_entry_t         r_entries [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_misalign;

    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_lane_data;
    logic              w_err;
    logic [ADDR_W-1:0] w_word_addr;
    logic              w_nonempty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_merge_hit;
    logic              w_ld_hit;
    logic              w_unused_ld_lane;
    sb_entry_t         w_head;

    store_lane_align u_align (
        .i_size (st_size),
        .i_lane (st_addr[1:0]),
        .i_data (st_data),
        .o_be   (w_be),
        .o_data (w_lane_data),
        .o_err  (w_err)
    );

    assign w_word_addr      = {st_addr[ADDR_W-1:2], 2'b00};
    assign w_nonempty       = (r_count != '0);
    assign w_full           = (r_count == FULL_CNT);
    assign w_pop            = w_nonempty & mem_wr_ready;
    assign w_head           = r_entries[r_head];
    assign w_unused_ld_lane = ^ld_addr[1:0];

`ifdef STORE_BUFFER_MERGE_EN
    logic [PTR_W-1:0] w_young;
    sb_entry_t        w_young_entry;
    sb_entry_t        w_merged;
    logic             w_merge;

    assign w_young       = r_tail - PTR_W'(1);
    assign w_young_entry = r_entries[w_young];
    // A lone entry that is leaving this cycle cannot absorb the store; it must allocate instead.
    assign w_merge_hit   = w_nonempty & w_young_entry.valid & !w_err
                         & (w_young_entry.addr == w_word_addr)
                         & !((r_count == CNT_W'(1)) & w_pop);
    assign w_merge       = st_valid & w_merge_hit;

    always_comb begin
        w_merged    = w_young_entry;
        w_merged.be = w_young_entry.be | w_be;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                w_merged.data[8*i +: 8] = w_lane_data[8*i +: 8];
            end
        end
    end
`else
    assign w_merge_hit = 1'b0;
`endif

    // Rejected requests are always consumed so a bad store never blocks the datapath.
    assign st_ready = w_err | w_merge_hit | !w_full;
    assign w_push   = st_valid & !w_err & !w_merge_hit & !w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            r_misalign <= st_valid & w_err;
            if (w_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_entries[r_tail] <= '{addr: w_word_addr, data: w_lane_data, be: w_be, valid: 1'b1};
                r_tail            <= r_tail + PTR_W'(1);
            end
`ifdef STORE_BUFFER_MERGE_EN
            if (w_merge) begin
                r_entries[w_young] <= w_merged;
            end
`endif
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Word-granular hazard check; entries draining this cycle still stall the load.
    always_comb begin
        w_ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_entries[i].valid && (r_entries[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
                w_ld_hit = 1'b1;
            end
        end
    end

    assign ld_stall     = ld_valid & w_ld_hit;
    assign misalign_err = r_misalign;
    assign empty        = !w_nonempty;
    assign mem_wr_valid = w_nonempty;
    assign mem_addr     = w_nonempty ? w_head.addr : '0;
    assign mem_wdata    = w_nonempty ? w_head.data : '0;
    assign mem_be       = w_nonempty ? w_head.be   : '0;

endmodule
